prog_loader_rom: RTL and testbench

Instruction memory plus program loader sitting directly upstream of the CPU. It supplies the 16-bit instruction word `ir` for the CPU's `pc`/`rom_en` fetch. Before execution it accepts a program as a byte stream over a valid/ready handshake and assembles byte pairs into 16-bit words. While loading it holds the CPU in reset, then releases it with a one-cycle `start` pulse.

---
 rtl/prog_loader_rom.sv | 113 +++++++++++
 tb/tb_prog_loader_rom.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_rom.sv
// Instruction store with byte-stream program loader.
// Holds the CPU in reset while a program is streamed in.
module prog_loader_rom #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              rom_en,
  output logic [DATA_W-1:0] ir,
  output logic              cpu_rst,
  output logic              start,
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    START,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [7:0]        hi;
  logic [ADDR_W-1:0] waddr;
  logic [8:0]        cnt;
  logic              xfer;
  logic              last;
  logic              req_ok;

  assign xfer   = byte_valid & byte_ready;
  assign last   = (cnt == 9'd1);
  assign req_ok = load_req & ((state == IDLE) | (state == RUN));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_req) state_nxt = LOAD_HI;
      LOAD_HI: if (xfer) state_nxt = LOAD_LO;
      LOAD_LO: if (xfer) state_nxt = last ? START : LOAD_HI;
      START:   state_nxt = RUN;
      RUN:     if (load_req) state_nxt = LOAD_HI;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    cpu_rst    = 1'b1;
    start      = 1'b0;
    unique case (1'b1)
      (state == LOAD_HI),
      (state == LOAD_LO): begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      (state == START): begin
        start   = 1'b1;
        cpu_rst = 1'b0;
      end
      (state == RUN): cpu_rst = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      waddr     <= '0;
      cnt       <= '0;
      load_done <= 1'b0;
      ir        <= '0;
    end else begin
      // a length of zero means a full 256-word image
      if (req_ok) begin
        cnt       <= (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
        waddr     <= '0;
        load_done <= 1'b0;
      end
      if ((state == LOAD_HI) && xfer) hi <= byte_data;
      if ((state == LOAD_LO) && xfer) begin
        waddr <= waddr + 1'b1;
        cnt   <= cnt - 9'd1;
      end
      if (state == START) load_done <= 1'b1;
      if ((state == RUN) && rom_en) ir <= mem[pc];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state == LOAD_LO) && xfer)
      mem[waddr] <= DATA_W'({hi, byte_data});
  end

endmodule

// File: tb/tb_prog_loader_rom.sv
// Bench for prog_loader_rom: vector table, directed
// load sequences and randomized loads against a memory model.
module tb_prog_loader_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [7:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [7:0]  pc;
  logic        rom_en;
  logic [15:0] ir;
  logic        cpu_rst;
  logic        start;
  logic        busy;
  logic        load_done;

  int total = 0;
  int bad = 0;

  logic [15:0] ref_mem [256];
  logic [15:0] model_ir;

  typedef struct {
    logic [7:0]  pc;
    logic        en;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  prog_loader_rom dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .pc         (pc),
    .rom_en     (rom_en),
    .ir         (ir),
    .cpu_rst    (cpu_rst),
    .start      (start),
    .busy       (busy),
    .load_done  (load_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic en);
    pc = a;
    rom_en = en;
    tick;
    rom_en = 1'b0;
    if (en) model_ir = ref_mem[a];
    chk("fetch_ir", ir, model_ir);
  endtask

  // mode 0: full rate, 1: valid 1-0-0-1, 2: random valid and noise
  task automatic load(input int n, input logic [15:0] w[$],
                      input int mode, input int abort_at);
    logic [7:0] q[$];
    int idx;
    int cyc;
    int starts;
    int busy_low;
    int nw;
    logic v;
    idx = 0;
    cyc = 0;
    starts = 0;
    busy_low = 0;
    nw = (n == 0) ? 256 : n;
    for (int i = 0; i < nw; i++) begin
      q.push_back(w[i][15:8]);
      q.push_back(w[i][7:0]);
    end
    rom_en = 1'b0;
    byte_valid = 1'b0;
    load_req = 1'b1;
    load_len = n[7:0];
    tick;
    load_req = 1'b0;
    chk("req_cpu_rst", cpu_rst, 1);
    chk("req_busy", busy, 1);
    chk("req_done_clr", load_done, 0);
    chk("req_ir_held", ir, model_ir);
    while (idx < q.size() && idx != abort_at && cyc < 4000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom);
      endcase
      byte_valid = v;
      byte_data = v ? q[idx] : 8'($urandom);
      if (mode == 2) begin
        load_req = 1'($urandom);
        load_len = 8'($urandom);
        rom_en = 1'($urandom);
        pc = 8'($urandom);
      end
      if (!busy) busy_low++;
      if (start) starts++;
      if (v && byte_ready) begin
        idx++;
        if (idx % 2 == 0)
          ref_mem[(idx / 2 - 1) % 256] = {q[idx-2], q[idx-1]};
      end
      tick;
      cyc++;
    end
    byte_valid = 1'b0;
    load_req = 1'b0;
    rom_en = 1'b0;
    chk("load_in_budget", 32'(cyc < 4000), 1);
    chk("busy_held", busy_low, 0);
    chk("no_early_start", starts, 0);
    if (abort_at >= 0) return;
    if (mode == 0) chk("full_rate_cycles", cyc, 2 * nw);
    chk("start_pulse", start, 1);
    chk("start_cpu_rst", cpu_rst, 0);
    chk("start_busy", busy, 0);
    chk("start_ready", byte_ready, 0);
    // a request during START must be dropped
    load_req = 1'b1;
    load_len = 8'd5;
    byte_valid = 1'b1;
    tick;
    load_req = 1'b0;
    byte_valid = 1'b0;
    chk("run_start_lo", start, 0);
    chk("run_done", load_done, 1);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_not_busy", busy, 0);
    chk("run_ir_held", ir, model_ir);
  endtask

  initial begin
    logic [15:0] w[$];

    rst = 1'b1;
    load_req = 1'b0;
    load_len = 8'd0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    pc = 8'd0;
    rom_en = 1'b0;
    tick;
    tick;
    chk("rst_ir", ir, 16'h0000);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", load_done, 0);
    rst = 1'b0;
    model_ir = 16'h0000;
    tick;
    chk("idle_fetch_ignored", ir, 16'h0000);

    w = '{16'h1234, 16'hABCD, 16'h00FF};
    load(3, w, 0, -1);

    tbl[0] = '{pc: 8'd0, en: 1'b1, exp: 16'h1234};
    tbl[1] = '{pc: 8'd1, en: 1'b1, exp: 16'hABCD};
    tbl[2] = '{pc: 8'd2, en: 1'b0, exp: 16'hABCD};
    tbl[3] = '{pc: 8'd2, en: 1'b1, exp: 16'h00FF};
    tbl[4] = '{pc: 8'd0, en: 1'b0, exp: 16'h00FF};
    for (int i = 0; i < 5; i++) begin
      pc = tbl[i].pc;
      rom_en = tbl[i].en;
      tick;
      rom_en = 1'b0;
      chk("tbl_ir", ir, tbl[i].exp);
    end
    model_ir = tbl[4].exp;

    for (int i = 0; i < 3; i++) ref_mem[i] = 16'hxxxx;
    load(3, w, 1, -1);
    for (int i = 0; i < 3; i++) fetch(8'(i), 1'b1);

    w = {};
    for (int i = 0; i < 256; i++) w.push_back({8'(i), ~8'(i)});
    load(0, w, 0, -1);
    fetch(8'd255, 1'b1);
    chk("wrap_255", ir, 16'hFF00);
    fetch(8'd0, 1'b1);
    chk("wrap_0", ir, 16'h00FF);
    for (int i = 0; i < 60; i++)
      fetch(8'($urandom), 1'($urandom));

    w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    load(4, w, 0, 5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_ir = 16'h0000;
    chk("abort_busy", busy, 0);
    chk("abort_cpu_rst", cpu_rst, 1);
    chk("abort_done", load_done, 0);
    chk("abort_start", start, 0);
    chk("abort_ir", ir, 16'h0000);
    tick;
    chk("abort_no_start", start, 0);
    chk("abort_idle", byte_ready, 0);
    w = '{16'h5A5A};
    load(1, w, 0, -1);
    fetch(8'd0, 1'b1);
    chk("reload_word", ir, 16'h5A5A);
    fetch(8'd1, 1'b1);
    fetch(8'd200, 1'b1);

    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 20);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      load(n, w, 2, -1);
      for (int i = 0; i < 25; i++)
        fetch(8'($urandom_range(0, 24)), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
